tile_renderer: RTL and testbench

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer.sv | 175 +++++++++++++++++
 tb/tb_tile_renderer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// tile_renderer: three-stage tile-map pixel colouriser with a frame-strobe
// snapshot of map and sprite coordinates.
// Optional feature macro: TILE_RENDERER_BLINK_EN (bullets blink on frame_cnt[3]).
module tile_renderer #(
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int TILE_SHIFT = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  int         TankX1,
  input  int         TankY1,
  input  int         BulX1,
  input  int         BulY1,
  input  int         TankX2,
  input  int         TankY2,
  input  int         BulX2,
  input  int         BulY2,
  input  int         map [MAP_W*MAP_H],
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic [7:0] frame_cnt
);

  localparam int N     = MAP_W * MAP_H;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Coordinate slots: 0 TankX1, 1 TankY1, 2 TankX2, 3 TankY2,
  //                   4 BulX1,  5 BulY1,  6 BulX2,  7 BulY2
  int         coord_in  [8];
  int         coord_reg [8];
  // Map codes are reduced to 0 empty / 1 wall / 2 brick when captured,
  // so any unknown code renders exactly like empty.
  logic [1:0] map_code_reg [N];

  logic       frame_prev_reg;
  logic       snap;
  logic [7:0] frame_cnt_reg;

  logic [9:0] tx1_reg, ty1_reg;
  logic       in_range1_reg;

  logic [1:0] tile2_reg, tile2_next;
  logic       in_range2_reg;
  logic       hit_t1_reg, hit_t2_reg, hit_b1_reg, hit_b2_reg;

  logic       bul_visible;

  assign snap      = frame_clk & ~frame_prev_reg;
  assign frame_cnt = frame_cnt_reg;

  // Gather the coordinate inputs into an indexable list
  always_comb begin
    coord_in[0] = TankX1;
    coord_in[1] = TankY1;
    coord_in[2] = TankX2;
    coord_in[3] = TankY2;
    coord_in[4] = BulX1;
    coord_in[5] = BulY1;
    coord_in[6] = BulX2;
    coord_in[7] = BulY2;
  end

  // Frame strobe edge register and snapshot counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_prev_reg <= 1'b0;
      frame_cnt_reg  <= 8'd0;
    end else begin
      frame_prev_reg <= frame_clk;
      if (snap) frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_coord
      // Shadow coordinate, -1 (off-map) until the first snapshot
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     coord_reg[gi] <= -1;
        else if (snap) coord_reg[gi] <= coord_in[gi];
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_map
      // Shadow tile code, captured on the snapshot pulse
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     map_code_reg[gi] <= 2'd0;
        else if (snap) map_code_reg[gi] <= (map[gi] == 1) ? 2'd1 :
                                           (map[gi] == 2) ? 2'd2 : 2'd0;
      end
    end
  endgenerate

  // A sprite hits only when its coordinates are on the map and equal the tile
  function automatic logic coord_hit(input int cx, input int cy,
                                     input logic [9:0] tx, input logic [9:0] ty);
    return (cx >= 0) && (cx < MAP_W) && (cy >= 0) && (cy < MAP_H) &&
           (cx == int'(tx)) && (cy == int'(ty));
  endfunction

  // Stage 1: tile coordinates and visible-area flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx1_reg       <= 10'd0;
      ty1_reg       <= 10'd0;
      in_range1_reg <= 1'b0;
    end else begin
      tx1_reg       <= DrawX >> TILE_SHIFT;
      ty1_reg       <= DrawY >> TILE_SHIFT;
      in_range1_reg <= (DrawX < 10'd640) && (DrawY < 10'd480);
    end
  end

  // Stage-2 map lookup, skipped entirely outside the visible area
  always_comb begin
    int               idx_int;
    logic [IDX_W-1:0] idx_sel;
    tile2_next = 2'd0;
    idx_int    = int'(ty1_reg) * MAP_W + int'(tx1_reg);
    idx_sel    = IDX_W'(idx_int);
    if (in_range1_reg && (int'(tx1_reg) < MAP_W) && (int'(ty1_reg) < MAP_H))
      tile2_next = map_code_reg[idx_sel];
  end

  // Stage 2: tile code and sprite hit flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tile2_reg     <= 2'd0;
      in_range2_reg <= 1'b0;
      hit_t1_reg    <= 1'b0;
      hit_t2_reg    <= 1'b0;
      hit_b1_reg    <= 1'b0;
      hit_b2_reg    <= 1'b0;
    end else begin
      tile2_reg     <= tile2_next;
      in_range2_reg <= in_range1_reg;
      hit_t1_reg    <= coord_hit(coord_reg[0], coord_reg[1], tx1_reg, ty1_reg);
      hit_t2_reg    <= coord_hit(coord_reg[2], coord_reg[3], tx1_reg, ty1_reg);
      hit_b1_reg    <= coord_hit(coord_reg[4], coord_reg[5], tx1_reg, ty1_reg);
      hit_b2_reg    <= coord_hit(coord_reg[6], coord_reg[7], tx1_reg, ty1_reg);
    end
  end

`ifdef TILE_RENDERER_BLINK_EN
  assign bul_visible = ~frame_cnt_reg[3];
`else
  assign bul_visible = 1'b1;
`endif

  // Stage 3: priority colour select
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {Red, Green, Blue} <= 24'h000000;
    end else if (!in_range2_reg) begin
      {Red, Green, Blue} <= 24'h000000;
    end else if (hit_t1_reg) begin
      {Red, Green, Blue} <= 24'h00FF00;
    end else if (hit_t2_reg) begin
      {Red, Green, Blue} <= 24'h0000FF;
    end else if ((hit_b1_reg || hit_b2_reg) && bul_visible) begin
      {Red, Green, Blue} <= 24'hFFFF00;
    end else if (tile2_reg == 2'd1) begin
      {Red, Green, Blue} <= 24'h808080;
    end else if (tile2_reg == 2'd2) begin
      {Red, Green, Blue} <= 24'hB04010;
    end else begin
      {Red, Green, Blue} <= 24'h000000;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer with a latency-aware expected-colour queue.
module tb_tile_renderer;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] DrawX, DrawY;
  int         TankX1, TankY1, BulX1, BulY1, TankX2, TankY2, BulX2, BulY2;
  int         map_arr [MAP_W*MAP_H];
  logic [7:0] Red, Green, Blue, frame_cnt;

  typedef struct {
    logic [23:0] exp;
    int          due;
    int          id;
  } exp_t;

  exp_t       sb[$];
  int         cyc    = 0;
  int         pid    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  tile_renderer #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_SHIFT(5)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY),
    .TankX1(TankX1), .TankY1(TankY1), .BulX1(BulX1), .BulY1(BulY1),
    .TankX2(TankX2), .TankY2(TankY2), .BulX2(BulX2), .BulY2(BulY2),
    .map(map_arr),
    .Red(Red), .Green(Green), .Blue(Blue), .frame_cnt(frame_cnt)
  );

  always #5 Clk = ~Clk;

  // One cycle: compare a due colour, then optionally present a new pixel
  task automatic step(input logic drv, input int x, input int y, input logic [23:0] exp);
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      assert ({Red, Green, Blue} === e.exp) else begin
        errors++;
        $error("FAIL pix%0d got %h exp %h", e.id, {Red, Green, Blue}, e.exp);
      end
    end
    if (drv) begin
      DrawX = 10'(x);
      DrawY = 10'(y);
      e.exp = exp; e.due = cyc + 3; e.id = pid;
      $display("pix%0d (%0d,%0d) expect %h", pid, x, y, exp);
      pid++;
      sb.push_back(e);
    end
  endtask

  task automatic flush();
    for (int k = 0; k < 10 && sb.size() > 0; k++) step(1'b0, 0, 0, 24'h0);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL flush got %0d pending exp 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] exp);
    step(1'b1, x, y, exp);
    flush();
  endtask

  task automatic snapshot();
    step(1'b0, 0, 0, 24'h0);
    frame_clk = 1'b1;
    step(1'b0, 0, 0, 24'h0);
    frame_clk = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic check_cnt(input string tag);
    checks++;
    assert (frame_cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, frame_cnt, exp_cnt);
    end
    $display("%s frame_cnt=%0d", tag, frame_cnt);
  endtask

  task automatic check_black(input string tag);
    checks++;
    assert ({Red, Green, Blue} === 24'h000000) else begin
      errors++;
      $error("FAIL %s got %h exp 000000", tag, {Red, Green, Blue});
    end
    $display("%s rgb=%h", tag, {Red, Green, Blue});
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
    TankX1 = -1; TankY1 = -1; BulX1 = -1; BulY1 = -1;
    TankX2 = -1; TankY2 = -1; BulX2 = -1; BulY2 = -1;
    foreach (map_arr[i]) map_arr[i] = 0;
    repeat (3) @(negedge Clk);
    check_black("reset_rgb");
    check_cnt("reset_cnt");
    Reset = 1'b0;

    // Map input alone does not reach the output before a snapshot
    map_arr[0] = 1;
    pix(5, 5, 24'h000000);
    snapshot();
    check_cnt("cnt_first");
    pix(5, 5, 24'h808080);
    pix(40, 5, 24'h000000);

    // Tank over bullet, then bullet alone
    TankX1 = 1; TankY1 = 13; BulX2 = 1; BulY2 = 13;
    snapshot();
    pix(40, 420, 24'h00FF00);
    pix(64, 420, 24'h000000);
    TankX1 = 2;
    snapshot();
    pix(40, 420, 24'hFFFF00);
    pix(64, 420, 24'h00FF00);

    // Tank priority
    TankX2 = 2; TankY2 = 13;
    snapshot();
    pix(64, 420, 24'h00FF00);
    TankX1 = 5;
    snapshot();
    pix(64, 420, 24'h0000FF);
    pix(160, 420, 24'h00FF00);

    // Map change without snapshot is invisible
    map_arr[2] = 2;
    pix(64, 0, 24'h000000);
    snapshot();
    pix(64, 0, 24'hB04010);

    // Visible-area boundaries and inactive bullets
    map_arr[MAP_W*MAP_H-1] = 1;
    BulX2 = -1; BulY2 = -1;
    snapshot();
    pix(650, 10, 24'h000000);
    pix(639, 479, 24'h808080);
    pix(640, 479, 24'h000000);
    pix(639, 480, 24'h000000);
    pix(40, 420, 24'h000000);

    // Back-to-back pixels, one per cycle
    step(1'b1, 5, 5, 24'h808080);
    step(1'b1, 64, 0, 24'hB04010);
    step(1'b1, 650, 10, 24'h000000);
    step(1'b1, 64, 420, 24'h0000FF);
    step(1'b1, 160, 420, 24'h00FF00);
    step(1'b1, 40, 420, 24'h000000);
    flush();

    // Snapshot while pixels are in flight
    map_arr[1] = 1;
    step(1'b1, 32, 0, 24'h000000);
    step(1'b1, 32, 0, 24'h808080);
    frame_clk = 1'b1;
    step(1'b0, 0, 0, 24'h0);
    frame_clk = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    flush();
    check_cnt("cnt_inflight");

    // Held strobe counts once
    frame_clk = 1'b1;
    repeat (10) step(1'b0, 0, 0, 24'h0);
    frame_clk = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    step(1'b0, 0, 0, 24'h0);
    check_cnt("cnt_held");

    // Wrap to zero
    while (exp_cnt != 8'd0) snapshot();
    step(1'b0, 0, 0, 24'h0);
    check_cnt("cnt_wrap");

    // Bullet at (3,3) over brick with frame_cnt = 8 and 16
    BulX1 = 3; BulY1 = 3;
    map_arr[3*MAP_W+3] = 2;
    repeat (8) snapshot();
    check_cnt("cnt_8");
`ifdef TILE_RENDERER_BLINK_EN
    pix(100, 100, 24'hB04010);
`else
    pix(100, 100, 24'hFFFF00);
`endif
    repeat (8) snapshot();
    check_cnt("cnt_16");
    pix(100, 100, 24'hFFFF00);

    // Reset mid-frame: in-flight pixel is discarded, shadow state cleared
    @(negedge Clk);
    DrawX = 10'd5; DrawY = 10'd5;
    #2 Reset = 1'b1;
    @(negedge Clk);
    check_black("midreset_rgb");
    exp_cnt = 8'd0;
    check_cnt("midreset_cnt");
    Reset = 1'b0;
    pix(5, 5, 24'h000000);
    pix(100, 100, 24'h000000);
    snapshot();
    pix(5, 5, 24'h808080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
